// File: rtl/branch_pkg.sv
// branch_pkg: shared state encoding and RV32 branch funct3 codes for branch resolution.
package branch_pkg;
    typedef enum logic [1:0] {IDLE, EVAL, REDIRECT, FLUSH} br_state_e;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
endpackage

// File: rtl/branch_comp.sv
// branch_comp: shared equality / signed-or-unsigned less-than comparator.
module branch_comp #(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] rs1,
    input  logic [DWIDTH-1:0] rs2,
    input  logic              branch_un_ctrl,
    output logic              branch_eq,
    output logic              branch_lt
);
    assign branch_eq = rs1 == rs2;
    assign branch_lt = branch_un_ctrl ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: one-at-a-time branch/jump resolution with held redirect and post-redirect flush.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int DWIDTH      = 32,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_funct3,
    input  logic              br_is_jump,
    input  logic [DWIDTH-1:0] rs1_data,
    input  logic [DWIDTH-1:0] rs2_data,
    input  logic [DWIDTH-1:0] br_target,
    output logic              resolve_valid,
    output logic              taken,
    output logic              illegal_funct,
    output logic              misaligned,
    output logic              redirect_valid,
    input  logic              redirect_ready,
    output logic [DWIDTH-1:0] redirect_pc,
    output logic              flush
);
    localparam int CW = (FLUSH_DEPTH > 0) ? $clog2(FLUSH_DEPTH + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((FLUSH_DEPTH > 0) ? FLUSH_DEPTH - 1 : 0);

    br_state_e         state;
    logic [2:0]        f3_q;
    logic              jump_q;
    logic [DWIDTH-1:0] rs1_q;
    logic [DWIDTH-1:0] rs2_q;
    logic [DWIDTH-1:0] target_q;
    logic [CW-1:0]     cnt;
    logic              eq;
    logic              lt;
    logic              taken_d;
    logic              illegal_d;
    logic              misaligned_d;

    branch_comp #(.DWIDTH(DWIDTH)) u_comp (
        .rs1           (rs1_q),
        .rs2           (rs2_q),
        .branch_un_ctrl(f3_q[1]),
        .branch_eq     (eq),
        .branch_lt     (lt)
    );

    // funct3 is meaningless for jumps, so the illegal strobe only applies to branches
    always_comb begin
        illegal_d    = !jump_q && (f3_q == 3'b010 || f3_q == 3'b011);
        taken_d      = jump_q || (f3_q == F3_BEQ ? eq :
                                  f3_q == F3_BNE ? !eq :
                                  (f3_q == F3_BLT || f3_q == F3_BLTU) ? lt :
                                  (f3_q == F3_BGE || f3_q == F3_BGEU) ? !lt : 1'b0);
        misaligned_d = taken_d && |target_q[1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            f3_q     <= '0;
            jump_q   <= 1'b0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            target_q <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: if (br_valid) begin
                    f3_q     <= br_funct3;
                    jump_q   <= br_is_jump;
                    rs1_q    <= rs1_data;
                    rs2_q    <= rs2_data;
                    target_q <= br_target;
                    state    <= EVAL;
                end
                EVAL: state <= (taken_d && !misaligned_d) ? REDIRECT : IDLE;
                REDIRECT: if (redirect_ready) begin
                    cnt   <= CNT_INIT;
                    state <= (FLUSH_DEPTH == 0) ? IDLE : FLUSH;
                end
                FLUSH: if (cnt == '0) state <= IDLE; else cnt <= cnt - CW'(1);
                default: state <= IDLE;
            endcase
        end
    end

    // state is forced to IDLE by reset, so only br_ready needs explicit gating
    assign br_ready       = rst_n && state == IDLE;
    assign resolve_valid  = state == EVAL;
    assign taken          = resolve_valid && taken_d;
    assign illegal_funct  = resolve_valid && illegal_d;
    assign misaligned     = resolve_valid && misaligned_d;
    assign redirect_valid = state == REDIRECT;
    assign redirect_pc    = redirect_valid ? target_q : '0;
    assign flush          = state == FLUSH;
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed checks of branch_resolve at FLUSH_DEPTH=2 and FLUSH_DEPTH=0.
module tb_branch_resolve;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        br_valid = 1'b0;
    logic [2:0]  br_funct3 = '0;
    logic        br_is_jump = 1'b0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [31:0] br_target = '0;
    logic        redirect_ready = 1'b0;

    logic        br_ready, resolve_valid, taken, illegal_funct, misaligned, redirect_valid, flush;
    logic [31:0] redirect_pc;
    logic        z_br_ready, z_resolve_valid, z_taken, z_illegal_funct, z_misaligned, z_redirect_valid, z_flush;
    logic [31:0] z_redirect_pc;
    logic        z_flush_seen = 1'b0;

    int pass = 0;
    int total = 0;

    always #5 clk = ~clk;

    always @(posedge clk or negedge clk) if (z_flush === 1'b1) z_flush_seen <= 1'b1;

    branch_resolve #(.DWIDTH(32), .FLUSH_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
        .br_funct3(br_funct3), .br_is_jump(br_is_jump), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .br_target(br_target), .resolve_valid(resolve_valid), .taken(taken),
        .illegal_funct(illegal_funct), .misaligned(misaligned), .redirect_valid(redirect_valid),
        .redirect_ready(redirect_ready), .redirect_pc(redirect_pc), .flush(flush)
    );

    branch_resolve #(.DWIDTH(32), .FLUSH_DEPTH(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(z_br_ready),
        .br_funct3(br_funct3), .br_is_jump(br_is_jump), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .br_target(br_target), .resolve_valid(z_resolve_valid), .taken(z_taken),
        .illegal_funct(z_illegal_funct), .misaligned(z_misaligned), .redirect_valid(z_redirect_valid),
        .redirect_ready(redirect_ready), .redirect_pc(z_redirect_pc), .flush(z_flush)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] f3, input logic jmp, input logic [31:0] a, input logic [31:0] b, input logic [31:0] tgt);
        br_valid = 1'b1; br_funct3 = f3; br_is_jump = jmp; rs1_data = a; rs2_data = b; br_target = tgt;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        total++; if (br_ready !== 1'b0) $display("FAIL reset_br_ready got %b exp 0", br_ready); else pass++;
        total++; if (redirect_pc !== 32'h0) $display("FAIL reset_redirect_pc got %h exp 0", redirect_pc); else pass++;
        total++; if ({resolve_valid, redirect_valid, flush} !== 3'b000) $display("FAIL reset_outputs got %b exp 000", {resolve_valid, redirect_valid, flush}); else pass++;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        total++; if (br_ready !== 1'b1) $display("FAIL release_br_ready got %b exp 1", br_ready); else pass++;
        total++; if (z_br_ready !== 1'b1) $display("FAIL release_z_br_ready got %b exp 1", z_br_ready); else pass++;
        tick();
    endtask

    task automatic test_beq_taken();
        issue(3'b000, 1'b0, 32'd5, 32'd5, 32'h100);
        tick(); br_valid = 1'b0;
        total++; if ({resolve_valid, taken, misaligned} !== 3'b110) $display("FAIL beq_resolve got %b exp 110", {resolve_valid, taken, misaligned}); else pass++;
        total++; if (br_ready !== 1'b0) $display("FAIL beq_busy got %b exp 0", br_ready); else pass++;
        tick();
        total++; if (redirect_valid !== 1'b1) $display("FAIL beq_redirect_valid got %b exp 1", redirect_valid); else pass++;
        total++; if (redirect_pc !== 32'h100) $display("FAIL beq_redirect_pc got %h exp 00000100", redirect_pc); else pass++;
        redirect_ready = 1'b1;
        tick(); redirect_ready = 1'b0;
        total++; if ({flush, redirect_valid} !== 2'b10) $display("FAIL beq_flush1 got %b exp 10", {flush, redirect_valid}); else pass++;
        tick();
        total++; if ({flush, br_ready} !== 2'b10) $display("FAIL beq_flush2 got %b exp 10", {flush, br_ready}); else pass++;
        tick();
        total++; if ({flush, br_ready} !== 2'b01) $display("FAIL beq_done got %b exp 01", {flush, br_ready}); else pass++;
    endtask

    task automatic test_blt_bltu();
        issue(3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h40);
        tick(); br_valid = 1'b0;
        total++; if ({resolve_valid, taken} !== 2'b11) $display("FAIL blt_taken got %b exp 11", {resolve_valid, taken}); else pass++;
        tick(); redirect_ready = 1'b1;
        total++; if (redirect_pc !== 32'h40) $display("FAIL blt_redirect_pc got %h exp 00000040", redirect_pc); else pass++;
        tick(); redirect_ready = 1'b0;
        tick(); tick();
        total++; if (br_ready !== 1'b1) $display("FAIL blt_ready got %b exp 1", br_ready); else pass++;
        issue(3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h40);
        tick(); br_valid = 1'b0;
        total++; if ({resolve_valid, taken} !== 2'b10) $display("FAIL bltu_not_taken got %b exp 10", {resolve_valid, taken}); else pass++;
        tick();
        total++; if ({br_ready, redirect_valid} !== 2'b10) $display("FAIL bltu_ready got %b exp 10", {br_ready, redirect_valid}); else pass++;
    endtask

    task automatic test_jump_illegal();
        issue(3'b000, 1'b1, 32'd1, 32'd2, 32'h202);
        tick(); br_valid = 1'b0;
        total++; if ({resolve_valid, taken, misaligned, illegal_funct} !== 4'b1110) $display("FAIL jump_misaligned got %b exp 1110", {resolve_valid, taken, misaligned, illegal_funct}); else pass++;
        tick();
        total++; if ({br_ready, redirect_valid} !== 2'b10) $display("FAIL jump_no_redirect got %b exp 10", {br_ready, redirect_valid}); else pass++;
        issue(3'b010, 1'b0, 32'd9, 32'd9, 32'h300);
        tick(); br_valid = 1'b0;
        total++; if ({resolve_valid, taken, illegal_funct, misaligned} !== 4'b1010) $display("FAIL illegal_f3 got %b exp 1010", {resolve_valid, taken, illegal_funct, misaligned}); else pass++;
        tick();
        total++; if ({br_ready, redirect_valid} !== 2'b10) $display("FAIL illegal_ready got %b exp 10", {br_ready, redirect_valid}); else pass++;
    endtask

    task automatic test_bne_stall();
        issue(3'b001, 1'b0, 32'd3, 32'd4, 32'h80);
        tick(); br_valid = 1'b0;
        total++; if (taken !== 1'b1) $display("FAIL bne_taken got %b exp 1", taken); else pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            br_valid = (i == 1); br_target = 32'h999; br_funct3 = 3'b000;
            total++; if ({redirect_valid, redirect_pc, br_ready} !== {1'b1, 32'h80, 1'b0}) $display("FAIL bne_hold%0d got %b %h %b exp 1 00000080 0", i, redirect_valid, redirect_pc, br_ready); else pass++;
        end
        tick(); br_valid = 1'b0;
        total++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'h80}) $display("FAIL bne_hold3 got %b %h exp 1 00000080", redirect_valid, redirect_pc); else pass++;
        redirect_ready = 1'b1;
        tick(); redirect_ready = 1'b0;
        tick(); tick();
        total++; if ({br_ready, resolve_valid, flush} !== 3'b100) $display("FAIL bne_done got %b exp 100", {br_ready, resolve_valid, flush}); else pass++;
        redirect_ready = 1'b1;
        tick(); redirect_ready = 1'b0;
        total++; if ({br_ready, resolve_valid, redirect_valid} !== 3'b100) $display("FAIL idle_redirect_ready got %b exp 100", {br_ready, resolve_valid, redirect_valid}); else pass++;
    endtask

    task automatic test_flush_depth0();
        issue(3'b000, 1'b0, 32'd7, 32'd7, 32'h10);
        tick(); br_valid = 1'b0;
        total++; if (z_taken !== 1'b1) $display("FAIL d0_taken got %b exp 1", z_taken); else pass++;
        tick();
        total++; if ({z_redirect_valid, z_redirect_pc} !== {1'b1, 32'h10}) $display("FAIL d0_redirect got %b %h exp 1 00000010", z_redirect_valid, z_redirect_pc); else pass++;
        redirect_ready = 1'b1;
        tick(); redirect_ready = 1'b0;
        total++; if ({z_br_ready, z_redirect_valid, z_flush} !== 3'b100) $display("FAIL d0_idle got %b exp 100", {z_br_ready, z_redirect_valid, z_flush}); else pass++;
        tick(); tick();
        total++; if (br_ready !== 1'b1) $display("FAIL d2_idle_after_d0 got %b exp 1", br_ready); else pass++;
    endtask

    task automatic test_reset_redirect();
        issue(3'b101, 1'b0, 32'd8, 32'd2, 32'h500);
        tick(); br_valid = 1'b0;
        tick();
        total++; if (redirect_valid !== 1'b1) $display("FAIL rst_pre_redirect got %b exp 1", redirect_valid); else pass++;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({redirect_valid, redirect_pc, br_ready} !== {1'b0, 32'h0, 1'b0}) $display("FAIL rst_mid got %b %h %b exp 0 00000000 0", redirect_valid, redirect_pc, br_ready); else pass++;
        tick(); rst_n = 1'b1;
        #1;
        total++; if (br_ready !== 1'b1) $display("FAIL rst_release_ready got %b exp 1", br_ready); else pass++;
        tick();
        total++; if ({resolve_valid, redirect_valid, flush, br_ready} !== 4'b0001) $display("FAIL rst_no_spurious got %b exp 0001", {resolve_valid, redirect_valid, flush, br_ready}); else pass++;
    endtask

    initial begin
        test_reset();
        test_beq_taken();
        test_blt_bltu();
        test_jump_illegal();
        test_bne_stall();
        test_flush_depth0();
        test_reset_redirect();
        total++; if (z_flush_seen !== 1'b0) $display("FAIL d0_flush_never got %b exp 0", z_flush_seen); else pass++;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
